// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the round-robin FIFO write arbiter.
package fifo_arb_pkg;

   localparam int unsigned MAX_NREQ = 8;
   localparam int unsigned PTR_W    = 3;
   localparam int unsigned BCNT_W   = 4;

   typedef enum logic {
      EMPTY = 1'b0,
      HOLD  = 1'b1
   } arb_state_t;

   // Rotate distance from ptr up to idx, wrapping at n.
   function automatic int unsigned rr_dist(input int unsigned idx, input int unsigned ptr,
                                           input int unsigned n);
      return (idx >= ptr) ? idx - ptr : idx + n - ptr;
   endfunction

   function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p,
                                                 input int unsigned n);
      return (32'(p) == n - 1) ? '0 : p + PTR_W'(1);
   endfunction

endpackage

// File: rtl/fifo_rr_pick.sv
// Combinational rotate-priority select: first set request at or above ptr, with wrap.
module fifo_rr_pick
   import fifo_arb_pkg::*;
#(
   parameter int unsigned NREQ = 4
) (
   input  logic [NREQ-1:0]  req_i,
   input  logic [PTR_W-1:0] ptr_i,
   output logic [NREQ-1:0]  win_oh_o,
   output logic [PTR_W-1:0] win_idx_o,
   output logic             win_vld_o
);

   logic found;

   always_comb begin
      win_oh_o  = '0;
      win_idx_o = '0;
      found     = 1'b0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         for (int unsigned i = 0; i < NREQ; i++) begin
            if (!found && req_i[i] && rr_dist(i, 32'(ptr_i), NREQ) == k) begin
               found       = 1'b1;
               win_oh_o[i] = 1'b1;
               win_idx_o   = PTR_W'(i);
            end
         end
      end
      win_vld_o = found;
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter sharing one FIFO write port among NREQ producers.
// Define FIFO_ARB_BURST_EN to let a winner keep priority for up to BURST_LEN grants.
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int unsigned NREQ      = 4,
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned BURST_LEN = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NREQ-1:0]       req_i,
   input  logic [NREQ*WIDTH-1:0] req_data_i,
   output logic [NREQ-1:0]       gnt_o,
   output logic                  fifo_wr_en_o,
   output logic [WIDTH-1:0]      fifo_din_o,
   input  logic                  fifo_full_i,
   output logic                  busy_o
);

   arb_state_t        state_q, state_d;
   logic [WIDTH-1:0]  din_q, din_d, din_sel;
   logic [PTR_W-1:0]  ptr_q, ptr_d, ptr_inc;
   logic [NREQ-1:0]   win_oh;
   logic [PTR_W-1:0]  win_idx;
   logic              win_vld, hold, drain, accept, grant;

   fifo_rr_pick #(
      .NREQ (NREQ)
   ) u_pick (
      .req_i     (req_i),
      .ptr_i     (ptr_q),
      .win_oh_o  (win_oh),
      .win_idx_o (win_idx),
      .win_vld_o (win_vld)
   );

   assign hold    = (state_q == HOLD);
   assign drain   = hold & ~fifo_full_i;
   assign accept  = ~hold | drain;
   assign grant   = accept & win_vld;
   assign gnt_o   = win_oh & {NREQ{accept}};
   assign ptr_inc = ptr_next(win_idx, NREQ);

   always_comb begin
      din_sel = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         din_sel |= req_data_i[i*WIDTH +: WIDTH] & {WIDTH{win_oh[i]}};
      end
   end

`ifdef FIFO_ARB_BURST_EN
   logic [BCNT_W-1:0] bcnt_q, bcnt_d, bcnt_cur;

   always_comb begin
      state_d  = state_q;
      din_d    = din_q;
      ptr_d    = ptr_q;
      bcnt_d   = bcnt_q;
      // ptr only rests on the current burst owner, so a different winner starts a new run.
      bcnt_cur = (win_idx == ptr_q) ? bcnt_q : '0;
      if (grant) begin
         state_d = HOLD;
         din_d   = din_sel;
         if (bcnt_cur < BCNT_W'(BURST_LEN - 1)) begin
            ptr_d  = win_idx;
            bcnt_d = bcnt_cur + BCNT_W'(1);
         end else begin
            ptr_d  = ptr_inc;
            bcnt_d = '0;
         end
      end else begin
         if (drain) begin
            state_d = EMPTY;
         end
         // Accepting with no grant means every request, the owner's included, has dropped.
         if (accept && bcnt_q != '0) begin
            bcnt_d = '0;
            ptr_d  = ptr_next(ptr_q, NREQ);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bcnt_q <= '0;
      end else begin
         bcnt_q <= bcnt_d;
      end
   end
`else
   logic unused_burst_len;
   assign unused_burst_len = ^BURST_LEN;

   always_comb begin
      state_d = state_q;
      din_d   = din_q;
      ptr_d   = ptr_q;
      if (grant) begin
         state_d = HOLD;
         din_d   = din_sel;
         ptr_d   = ptr_inc;
      end else if (drain) begin
         state_d = EMPTY;
      end
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= EMPTY;
         din_q   <= '0;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         din_q   <= din_d;
         ptr_q   <= ptr_d;
      end
   end

   assign fifo_wr_en_o = hold;
   assign fifo_din_o   = din_q;
   assign busy_o       = hold | (|req_i);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: directed cases plus randomized req/full traffic.
module tb_fifo_wr_arbiter;

   localparam int NREQ  = 4;
   localparam int WIDTH = 8;
`ifdef FIFO_ARB_BURST_EN
   localparam int BLEN  = 3;
   localparam int LIMIT = NREQ * BLEN;
`else
   localparam int BLEN  = 4;
   localparam int LIMIT = NREQ;
`endif

   logic                  clk = 1'b0;
   logic                  rst_n = 1'b0;
   logic [NREQ-1:0]       req = '0;
   logic [NREQ*WIDTH-1:0] req_data = '0;
   logic                  fifo_full = 1'b0;
   logic [NREQ-1:0]       gnt;
   logic                  fifo_wr_en;
   logic [WIDTH-1:0]      fifo_din;
   logic                  busy;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   fifo_wr_arbiter #(
      .NREQ      (NREQ),
      .WIDTH     (WIDTH),
      .BURST_LEN (BLEN)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_i        (req),
      .req_data_i   (req_data),
      .gnt_o        (gnt),
      .fifo_wr_en_o (fifo_wr_en),
      .fifo_din_o   (fifo_din),
      .fifo_full_i  (fifo_full),
      .busy_o       (busy)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: spec-level state updated once per cycle, just before the rising edge.
   int               m_ptr, m_valid, m_din, holder, run;
   int               m_w, m_idx;
   int               wait_cnt [NREQ];
   bit               m_drain, m_accept;
   logic [NREQ-1:0]  m_gnt;
   logic [WIDTH-1:0] exp_q [$];

   always @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_ptr   = 0;
         m_valid = 0;
         m_din   = 0;
         holder  = -1;
         run     = 0;
         exp_q.delete();
         for (int i = 0; i < NREQ; i++) wait_cnt[i] = 0;
      end else begin
         m_drain  = (m_valid != 0) && !fifo_full;
         m_accept = (m_valid == 0) || m_drain;
         m_w = -1;
         for (int k = 0; k < NREQ; k++) begin
            m_idx = (m_ptr + k) % NREQ;
            if (m_w < 0 && req[m_idx]) m_w = m_idx;
         end
         m_gnt = (m_accept && m_w >= 0) ? NREQ'(1 << m_w) : '0;
         chk("gnt", 32'(gnt), 32'(m_gnt));
         chk("wr_en", 32'(fifo_wr_en), m_valid);
         chk("din", 32'(fifo_din), m_din);
         chk("busy", 32'(busy), 32'((m_valid != 0) || (|req)));
         if (m_gnt != '0) begin
            for (int i = 0; i < NREQ; i++) begin
               if (i == m_w) begin
                  wait_cnt[i] = 0;
               end else if (req[i]) begin
                  wait_cnt[i]++;
                  chk("fair_wait", 32'(wait_cnt[i] <= LIMIT), 1);
               end
            end
            m_din   = int'(req_data[m_w*WIDTH +: WIDTH]);
            m_valid = 1;
            exp_q.push_back(req_data[m_w*WIDTH +: WIDTH]);
`ifdef FIFO_ARB_BURST_EN
            run    = (m_w == holder) ? run + 1 : 1;
            holder = m_w;
            if (run >= BLEN) begin
               m_ptr = (m_w + 1) % NREQ;
               run   = 0;
            end else begin
               m_ptr = m_w;
            end
`else
            m_ptr = (m_w + 1) % NREQ;
`endif
         end else begin
            if (m_drain) m_valid = 0;
            if (m_accept && run > 0) begin
               run   = 0;
               m_ptr = (holder + 1) % NREQ;
            end
         end
         for (int i = 0; i < NREQ; i++) if (!req[i]) wait_cnt[i] = 0;
      end
   end

   // Monitor: every FIFO write must match the oldest granted byte.
   logic [WIDTH-1:0] exp_byte;

   always @(negedge clk) begin
      if (rst_n && fifo_wr_en && !fifo_full) begin
         if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL sb_write: wrote %0h, expected no write (nothing granted)", fifo_din);
         end else begin
            exp_byte = exp_q.pop_front();
            chk("sb_write", 32'(fifo_din), 32'(exp_byte));
         end
      end
   end

   logic [NREQ-1:0] rr_tbl [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
   logic [WIDTH-1:0] din_tbl [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
   logic [NREQ-1:0] bt_tbl [7] = '{4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0010,
                                   4'b0001};
   logic [NREQ-1:0] g;

   task automatic next_drive();
      @(posedge clk);
      #1;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("rst_gnt", 32'(gnt), 0);
      chk("rst_wr_en", 32'(fifo_wr_en), 0);
      chk("rst_din", 32'(fifo_din), 0);
      chk("rst_busy", 32'(busy), 0);

`ifndef FIFO_ARB_BURST_EN
      next_drive();
      req      = 4'b1111;
      req_data = 32'h44332211;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk("rr_gnt", 32'(gnt), 32'(rr_tbl[c]));
         if (c > 0) begin
            chk("rr_din", 32'(fifo_din), 32'(din_tbl[c-1]));
            chk("rr_wr_en", 32'(fifo_wr_en), 1);
         end
         next_drive();
      end
      req = '0;
      repeat (2) next_drive();

      // Stall: ptr sits at requester 1 here.
      req      = 4'b1010;
      req_data = 32'h33001100;
      @(negedge clk);
      chk("stall_first_gnt", 32'(gnt), 32'(4'b0010));
      next_drive();
      req       = 4'b1000;
      fifo_full = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("stall_din", 32'(fifo_din), 32'h11);
         chk("stall_wr_en", 32'(fifo_wr_en), 1);
         chk("stall_gnt", 32'(gnt), 0);
         next_drive();
      end
      fifo_full = 1'b0;
      @(negedge clk);
      chk("unstall_gnt", 32'(gnt), 32'(4'b1000));
      chk("unstall_din", 32'(fifo_din), 32'h11);
      next_drive();
      req = '0;
      repeat (2) next_drive();

      // Single requester toggling; ptr ends on requester 3.
      req = 4'b0100;
      @(negedge clk);
      chk("tog_gnt1", 32'(gnt), 32'(4'b0100));
      next_drive();
      req = 4'b0000;
      @(negedge clk);
      chk("tog_gnt0", 32'(gnt), 0);
      next_drive();
      req = 4'b0100;
      @(negedge clk);
      chk("tog_gnt2", 32'(gnt), 32'(4'b0100));
      next_drive();
      req = 4'b1001;
      @(negedge clk);
      chk("tog_wrap", 32'(gnt), 32'(4'b1000));
      next_drive();
      req = 4'b0001;
      @(negedge clk);
      chk("tog_after", 32'(gnt), 32'(4'b0001));
      next_drive();
      req = '0;
      repeat (2) next_drive();

      // Asynchronous reset while holding 0x5A; ptr would otherwise point at requester 3.
      req      = 4'b0100;
      req_data = 32'h005A0000;
      @(negedge clk);
      chk("hold_gnt", 32'(gnt), 32'(4'b0100));
      next_drive();
      req       = '0;
      fifo_full = 1'b1;
      @(negedge clk);
      chk("hold_din", 32'(fifo_din), 32'h5A);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_wr_en", 32'(fifo_wr_en), 0);
      chk("arst_din", 32'(fifo_din), 0);
      #1 rst_n = 1'b1;
      fifo_full = 1'b0;
      next_drive();
      req = 4'b1111;
      @(negedge clk);
      chk("arst_ptr", 32'(gnt), 32'(4'b0001));
      next_drive();
      req = '0;
      repeat (2) next_drive();
`else
      next_drive();
      req      = 4'b0011;
      req_data = 32'h0000BBAA;
      for (int c = 0; c < 7; c++) begin
         @(negedge clk);
         chk("burst_gnt", 32'(gnt), 32'(bt_tbl[c]));
         next_drive();
      end
      req = 4'b0010;
      @(negedge clk);
      chk("burst_drop", 32'(gnt), 32'(4'b0010));
      next_drive();
      req = '0;
      repeat (2) next_drive();
`endif

      for (int cyc = 0; cyc < 10000; cyc++) begin
         @(negedge clk);
         g = gnt;
         next_drive();
         for (int i = 0; i < NREQ; i++) begin
            if (g[i] || !req[i]) begin
               req_data[i*WIDTH +: WIDTH] = WIDTH'($urandom);
               req[i] = ($urandom_range(0, 2) != 0);
            end else if ($urandom_range(0, 19) == 0) begin
               req[i] = 1'b0;
            end
         end
         fifo_full = ($urandom_range(0, 3) == 0);
      end

      req       = '0;
      fifo_full = 1'b0;
      repeat (4) next_drive();
      @(negedge clk);
      chk("sb_flush", 32'(exp_q.size()), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write arbiter that shares one `fifo_8bit` write port among `NREQ` producers. Each cycle it selects at most one requesting producer, captures that producer's byte into a one-entry output register, and drives the FIFO's `wr_en`/`din`. The output register holds its entry against `full` until the FIFO accepts it, so no data is lost. Sustained throughput is one write per cycle. The block sits between the producer engines and the FIFO, on the FIFO's `clk`.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `WIDTH`, 8: data width; must match the FIFO's `WIDTH`.
- `BURST_LEN`, 4: maximum consecutive grants to one requester; used only with `FIFO_ARB_BURST_EN`; range 1..15.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  NREQ  per-requester request; level, held until granted.
- `req_data`  in  NREQ*WIDTH  packed data; slice i = `req_data[i*WIDTH +: WIDTH]`.
- `gnt`  out  NREQ  one-hot or zero, combinational; `gnt[i]`=1 means slice i is captured at this edge.
- `fifo_wr_en`  out  1  registered; output entry valid.
- `fifo_din`  out  WIDTH  registered output data.
- `fifo_full`  in  1  FIFO `full`.
- `busy`  out  1  `fifo_wr_en | (|req)`.

## Operation
- Output stage states:
  - EMPTY: `fifo_wr_en`=0.
  - HOLD: `fifo_wr_en`=1.
- `drain` = `fifo_wr_en & ~fifo_full`; the FIFO writes on this same edge.
- `accept` = EMPTY, or `drain`.
- `gnt` = `pick(req, ptr) & {NREQ{accept}}`. The grant never depends on `fifo_full` except through `accept`.
- On an edge with a grant:
  - `fifo_din` ← winning slice; state → HOLD.
  - `ptr` ← winner+1, mod `NREQ`.
- On an edge with `drain` and no grant: state → EMPTY; `fifo_din` holds its value.
- HOLD with `fifo_full`=1: everything is frozen and `gnt`=0.
- `pick`: first set bit of `req`, searching from `ptr` upward with wrap. No request gives zero. Wrap at `NREQ-1` → 0.
- A requester may change `req_data` only in the cycle after its `gnt`.
- A producer deasserting `req` before its grant is legal; it is simply not picked.
- Reset (async, any time), all forced to 0:
  - `fifo_wr_en`, `fifo_din`, `ptr` (requester 0 highest), burst counter.
  - An entry in HOLD is discarded. Its producer has already seen `gnt`; a reset mid-operation therefore loses at most one byte, and this is accepted.

## Timing
- Request to `gnt`: 0 cycles, when `accept`=1.
- `gnt` edge to `fifo_wr_en`=1: 1 cycle.
- FIFO write: the first edge with `fifo_wr_en & ~fifo_full`.
- Back-to-back throughput: one grant per cycle while `fifo_full`=0.
- `full` rising one cycle after a write is covered: the entry sits in HOLD and no grant is issued.
- Outputs after `rst_n` deasserts:
  - `gnt`=0 until the first cycle with `req`≠0.
  - `fifo_wr_en`=0.
  - `busy` = `|req`.

## Configuration
- `FIFO_ARB_BURST_EN` defined:
  - The winner keeps priority: `ptr` is not advanced while `burst_cnt` < `BURST_LEN`-1 and its `req` is still set.
  - `burst_cnt` increments per grant to the same requester.
  - `burst_cnt` clears on a winner change or when `req` of the winner drops; `ptr` then advances past it.
  - `burst_cnt` reaching `BURST_LEN`-1 forces advance.
- `FIFO_ARB_BURST_EN` undefined:
  - `ptr` advances on every grant (pure round-robin).
  - No burst counter flops exist; `BURST_LEN` is ignored.

## Structure
- Package `fifo_arb_pkg`: `MAX_NREQ`=8, `PTR_W`=3, `BCNT_W`=4, and a typedef `arb_state_t` {EMPTY, HOLD}.
- One sub-module, `fifo_rr_pick`: combinational rotate-priority select. Inputs `req` and `ptr`; outputs a one-hot winner and its index. Parameter `NREQ`.
- Top level holds the output register, the state, `ptr`, and the optional burst counter.

## Test plan
- Reset, then `req`=4'b1111 with `fifo_full`=0 (no burst):
  - `gnt` sequence 0001, 0010, 0100, 1000, 0001.
  - `fifo_din` follows one cycle later.
  - Five writes in five cycles.
- `req`=4'b1010, data 0x11 on req1 and 0x33 on req3, `fifo_full`=1 after the first grant:
  - 0x11 held on `fifo_din` with `fifo_wr_en`=1 and `gnt`=0 for the whole stall.
  - On `full`→0, 0x11 is written and req3 is granted in that same cycle.
- `req` toggling on a single requester (req2 only, 1,0,1): every assertion gets `gnt` in the same cycle, and `ptr` wraps to requester 3.
- `rst_n` pulsed low mid-cycle while in HOLD with 0x5A: `fifo_wr_en` and `fifo_din` go to 0 immediately with no clock, and `ptr` returns to 0.
- With `FIFO_ARB_BURST_EN`, `BURST_LEN`=3, and `req`=4'b0011 held:
  - `gnt` sequence 01, 01, 01, 10, 10, 10, 01.
  - Dropping req0 mid-burst hands over to requester 1 on the next grant.
- Scoreboard over 10k random `req` and `fifo_full` patterns:
  - Every granted byte is written exactly once and in order.
  - No requester waits more than `NREQ` grants (no burst) or `NREQ`×`BURST_LEN` grants (burst).
